// File: rtl/board_mem_if.sv
// board_mem_if: requester handshakes and RAM bus shared between arbiter and its neighbours
interface board_mem_if #(
  parameter int ADDR_W = 5,
  parameter int CELL_W = 2
);
  logic                  g_req;
  logic                  g_we;
  logic [ADDR_W:0]       g_cell;
  logic [CELL_W-1:0]     g_wdata;
  logic                  g_ack;
  logic [CELL_W-1:0]     g_rdata;
  logic                  d_req;
  logic [ADDR_W:0]       d_cell;
  logic                  d_ack;
  logic [CELL_W-1:0]     d_rdata;
  logic [ADDR_W-1:0]     ram_address;
  logic [2*CELL_W-1:0]   ram_data;
  logic                  ram_wren;
  logic [2*CELL_W-1:0]   ram_q;
  logic                  busy;
  modport slave (
    input  g_req, g_we, g_cell, g_wdata, d_req, d_cell, ram_q,
    output g_ack, g_rdata, d_ack, d_rdata, ram_address, ram_data, ram_wren, busy
  );
  modport master (
    output g_req, g_we, g_cell, g_wdata, d_req, d_cell, ram_q,
    input  g_ack, g_rdata, d_ack, d_rdata, ram_address, ram_data, ram_wren, busy
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the packed 2-cells-per-word board RAM between game and display ports
module board_mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int CELL_W = 2
) (
  input  logic       clk,
  input  logic       resetn,
  board_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic GAME = 1'b0;
  localparam logic DISP = 1'b1;
  state_t                r_state, w_next;
  logic                  r_last_grant, r_port, r_we;
  logic [ADDR_W:0]       r_cell;
  logic [CELL_W-1:0]     r_wdata;
  logic                  r_g_ack, r_d_ack, r_ram_wren, r_busy;
  logic [CELL_W-1:0]     r_g_rdata, r_d_rdata;
  logic [ADDR_W-1:0]     r_ram_address;
  logic [2*CELL_W-1:0]   r_ram_data;
  logic                  w_grant, w_grant_d;
  logic [ADDR_W:0]       w_sel_cell;
  logic [CELL_W-1:0]     w_half;
  logic [2*CELL_W-1:0]   w_merged;
  assign w_grant    = (r_state == IDLE) && (bus.g_req || bus.d_req);
  assign w_grant_d  = bus.d_req && (!bus.g_req || r_last_grant == GAME);
  assign w_sel_cell = w_grant_d ? bus.d_cell : bus.g_cell;
  assign w_half     = r_cell[0] ? bus.ram_q[2*CELL_W-1:CELL_W] : bus.ram_q[CELL_W-1:0];
  assign w_merged   = r_cell[0] ? {r_wdata, bus.ram_q[CELL_W-1:0]} : {bus.ram_q[2*CELL_W-1:CELL_W], r_wdata};
  assign bus.g_ack       = r_g_ack;
  assign bus.g_rdata     = r_g_rdata;
  assign bus.d_ack       = r_d_ack;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.ram_address = r_ram_address;
  assign bus.ram_data    = r_ram_data;
  assign bus.ram_wren    = r_ram_wren;
  assign bus.busy        = r_busy;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: a grant starts a word read, writes add a read-modify-write cycle
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)  ? (w_grant ? READ : IDLE) :
             (r_state == READ)  ? (r_we ? WRITE : DONE) :
             (r_state == WRITE) ? DONE : IDLE;
  end
  // datapath: latch the granted request, split/merge cells, pulse acks and write enable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant  <= DISP;
      r_port        <= GAME;
      r_we          <= 1'b0;
      r_cell        <= '0;
      r_wdata       <= '0;
      r_g_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      r_g_rdata     <= '0;
      r_d_rdata     <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_busy     <= (w_next != IDLE);
      r_g_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_ram_wren <= 1'b0;
      if (w_grant) begin
        r_port        <= w_grant_d;
        r_we          <= !w_grant_d && bus.g_we;
        r_cell        <= w_sel_cell;
        r_wdata       <= bus.g_wdata;
        r_ram_address <= w_sel_cell[ADDR_W:1];
        r_last_grant  <= w_grant_d;
      end
      if (r_state == READ) begin
        if (r_we) begin
          r_ram_data <= w_merged;
          r_ram_wren <= 1'b1;
        end else if (r_port == DISP) begin
          r_d_rdata <= w_half;
          r_d_ack   <= 1'b1;
        end else begin
          r_g_rdata <= w_half;
          r_g_ack   <= 1'b1;
        end
      end
      if (r_state == WRITE) r_g_ack <= 1'b1;
    end
  end
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: directed checks of arbitration, cell packing, latency and reset abort
module tb_board_mem_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] mem [32] = '{default: 4'h0};
  logic       pl_en = 1'b0;
  logic [4:0] pl_a = '0;
  logic [3:0] pl_d = '0;
  int         wr_count = 0;
  board_mem_if #(.ADDR_W(5), .CELL_W(2)) bus ();
  board_mem_arbiter #(.ADDR_W(5), .CELL_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );
  always #5 clk = ~clk;
  assign bus.ram_q = mem[bus.ram_address];
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (bus.ram_wren) begin
      mem[bus.ram_address] <= bus.ram_data;
      wr_count <= wr_count + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [4:0] a, input logic [3:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en = 1'b0;
  endtask
  task automatic wr_vs_rd(input logic exp_g_first);
    logic gdone, ddone, gfirst;
    logic [1:0] dval;
    gdone = 0; ddone = 0; gfirst = 0; dval = 'x;
    bus.g_req = 1; bus.g_we = 1; bus.g_cell = 6'd63; bus.g_wdata = 2'b10;
    bus.d_req = 1; bus.d_cell = 6'd62;
    for (int c = 0; c < 40 && !(gdone && ddone); c++) begin
      step();
      if (bus.g_ack) begin
        bus.g_req = 0;
        gfirst = !ddone;
        gdone = 1;
      end
      if (bus.d_ack) begin
        bus.d_req = 0;
        dval = bus.d_rdata;
        ddone = 1;
      end
    end
    chk("wr_rd_both_done", {gdone, ddone}, 2'b11);
    chk("wr_rd_order_game_first", gfirst, exp_g_first);
    chk("wr_rd_display_value", dval, 2'b11);
    chk("wr_rd_word31", mem[31], 4'b1011);
    step();
    step();
  endtask
  initial begin
    int n, overlap, w0;
    logic [5:0] order;
    bus.g_req = 0; bus.g_we = 0; bus.g_cell = '0; bus.g_wdata = '0;
    bus.d_req = 0; bus.d_cell = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("reset_g_ack", bus.g_ack, 0);
    chk("reset_d_ack", bus.d_ack, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_wren", bus.ram_wren, 0);
    chk("reset_address", bus.ram_address, 0);
    preload(5'd9, 4'b1000);
    preload(5'd31, 4'b0011);
    preload(5'd2, 4'b0110);
    resetn = 1'b1;
    step();
    // game write cell 18 <= 11 into word 9 = 1000
    w0 = wr_count;
    bus.g_req = 1; bus.g_we = 1; bus.g_cell = 6'd18; bus.g_wdata = 2'b11;
    step();
    chk("w18_e1_busy", bus.busy, 1);
    chk("w18_e1_addr", bus.ram_address, 9);
    chk("w18_e1_ack", bus.g_ack, 0);
    step();
    chk("w18_e2_wren", bus.ram_wren, 1);
    chk("w18_e2_data", bus.ram_data, 4'b1011);
    chk("w18_e2_ack", bus.g_ack, 0);
    step();
    chk("w18_e3_ack", bus.g_ack, 1);
    chk("w18_e3_wren", bus.ram_wren, 0);
    bus.g_req = 0;
    step();
    chk("w18_e4_ack", bus.g_ack, 0);
    chk("w18_e4_busy", bus.busy, 0);
    chk("w18_wr_pulses", wr_count - w0, 1);
    chk("w18_word9", mem[9], 4'b1011);
    // game read cell 19: upper half of 1011
    w0 = wr_count;
    bus.g_req = 1; bus.g_we = 0; bus.g_cell = 6'd19;
    step();
    chk("r19_e1_ack", bus.g_ack, 0);
    step();
    chk("r19_e2_ack", bus.g_ack, 1);
    chk("r19_rdata", bus.g_rdata, 2'b10);
    chk("r19_d_ack", bus.d_ack, 0);
    bus.g_req = 0;
    step();
    chk("r19_ack_pulse", bus.g_ack, 0);
    chk("r19_rdata_held", bus.g_rdata, 2'b10);
    step();
    chk("r19_no_write", wr_count - w0, 0);
    // display-only read cell 62 (word 31 low half)
    bus.d_req = 1; bus.d_cell = 6'd62;
    step();
    step();
    chk("d62_ack", bus.d_ack, 1);
    chk("d62_rdata", bus.d_rdata, 2'b11);
    chk("d62_g_ack", bus.g_ack, 0);
    bus.d_req = 0;
    step();
    step();
    // continuous contention: expect G, D, G, D, G, D
    bus.g_req = 1; bus.g_we = 0; bus.g_cell = 6'd0;
    bus.d_req = 1; bus.d_cell = 6'd1;
    n = 0; overlap = 0; order = 'x;
    for (int c = 0; c < 80 && n < 6; c++) begin
      step();
      if (bus.g_ack && bus.d_ack) overlap++;
      if (bus.g_ack || bus.d_ack) begin
        order[n] = bus.d_ack;
        n++;
      end
    end
    bus.g_req = 0; bus.d_req = 0;
    chk("fair_count", n, 6);
    chk("fair_overlap", overlap, 0);
    chk("fair_order", order, 6'b101010);
    step();
    step();
    chk("fair_idle_busy", bus.busy, 0);
    // write cell 63 vs display read cell 62, game granted first
    wr_vs_rd(1'b1);
    // restore word 31, make game the last grant, then display wins the tie
    preload(5'd31, 4'b0011);
    bus.g_req = 1; bus.g_we = 0; bus.g_cell = 6'd62;
    step();
    step();
    chk("g62_ack", bus.g_ack, 1);
    chk("g62_rdata", bus.g_rdata, 2'b11);
    bus.g_req = 0;
    step();
    step();
    wr_vs_rd(1'b0);
    // reset while ram_wren is high: write cell 4 <= 11 into word 2 = 0110
    bus.g_req = 1; bus.g_we = 1; bus.g_cell = 6'd4; bus.g_wdata = 2'b11;
    step();
    step();
    chk("rst_pre_wren", bus.ram_wren, 1);
    chk("rst_pre_data", bus.ram_data, 4'b0111);
    resetn = 1'b0;
    #1;
    chk("rst_wren", bus.ram_wren, 0);
    chk("rst_g_ack", bus.g_ack, 0);
    chk("rst_busy", bus.busy, 0);
    bus.g_req = 0;
    step();
    resetn = 1'b1;
    chk("rst_word2_untouched", mem[2], 4'b0110);
    step();
    chk("rst_idle_busy", bus.busy, 0);
    chk("rst_no_ack", bus.g_ack, 0);
    // game write cell 5 <= 11, inputs changed after grant are ignored
    bus.g_req = 1; bus.g_we = 1; bus.g_cell = 6'd5; bus.g_wdata = 2'b11;
    step();
    chk("chg_e1_busy", bus.busy, 1);
    chk("chg_e1_addr", bus.ram_address, 2);
    bus.g_cell = 6'd6; bus.g_wdata = 2'b00;
    step();
    chk("chg_e2_wren", bus.ram_wren, 1);
    chk("chg_e2_data", bus.ram_data, 4'b1110);
    step();
    chk("chg_e3_ack", bus.g_ack, 1);
    bus.g_req = 0;
    step();
    chk("chg_word2", mem[2], 4'b1110);
    chk("chg_word3", mem[3], 4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
